// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin multi-requester APB master with pready timeout
module apb_req_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_W-1:0]         paddr,
   output logic [DATA_W-1:0]         pwdata,
   input  logic [DATA_W-1:0]         prdata,
   input  logic                      pready,
   input  logic                      pslverr
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int PW = IW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
   state_t              state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d, gnt_q, gnt_d, sel;
   logic [PW-1:0]       idx;
   logic                found;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d, rdata_q, rdata_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic                err_q, err_d;
   // Pick the first requesting index at or above the pointer, wrapping; lowest offset wins
   always_comb begin
      found = 1'b0;
      sel   = ptr_q;
      idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = PW'(ptr_q) + PW'(i);
         if (idx >= PW'(NUM_REQ)) idx = idx - PW'(NUM_REQ);
         if (req[idx[IW-1:0]]) begin
            found = 1'b1;
            sel   = idx[IW-1:0];
         end
      end
   end
   // Next-state and registered-output logic; response fields are one-cycle pulses
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      done_d    = '0;
      rdata_d   = '0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: if (found) begin
            gnt_d     = sel;
            pwrite_d  = req_write[sel];
            paddr_d   = req_addr[sel*ADDR_W +: ADDR_W];
            pwdata_d  = req_wdata[sel*DATA_W +: DATA_W];
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = SETUP;
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: if (pready) begin
            rdata_d       = pwrite_q ? '0 : prdata;
            err_d         = pslverr;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            done_d[gnt_q] = 1'b1;
            state_d       = DONE;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(TIMEOUT)) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               err_d         = 1'b1;
               done_d[gnt_q] = 1'b1;
               state_d       = DONE;
            end
         end
         DONE: begin
            ptr_d   = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // State and output registers; reset drops the bus and any in-flight transfer
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gnt_q     <= '0;
         cnt_q     <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end
   assign done      = done_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Multi-requester APB master that shares one APB completer (e.g. apb_ram) between NUM_REQ requesters.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases.
- Waits on pready, returns read data and error status to the granted requester, and aborts hung transfers with a timeout.
- Sits between on-chip request sources and the APB slave bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles with pready low before abort (>=1)

Ports:
- pclk  input  1  bus clock, all logic on rising edge
- preset  input  1  asynchronous active-high reset
- req  input  NUM_REQ  per-requester request level
- req_write  input  NUM_REQ  per-requester direction, 1=write
- req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data
- done  output  NUM_REQ  one-cycle completion pulse to granted requester
- rsp_rdata  output  DATA_W  read data, valid while done!=0
- rsp_err  output  1  error flag, valid while done!=0
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_W  APB address
- pwdata  output  DATA_W  APB write data
- prdata  input  DATA_W  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB slave error

Behaviour:
- Reset: all outputs 0, FSM=IDLE, round-robin pointer=0 (requester 0 highest), timeout counter 0.
- Reset asserted mid-transfer: bus released immediately; transfer dropped with no done pulse.
- Requester protocol:
  - hold req=1 with fields stable until the first cycle of the grant;
  - fields are latched at grant, so later changes or dropping req do not affect the transfer;
  - requester observes done=1 and drops req (or presents a new request) on that edge.
- FSM, all outputs registered:
  - IDLE: if any req, grant first set bit searching from pointer upward with wrap; latch paddr/pwrite/pwdata, psel<=1, penable<=0 -> SETUP. No req: stay IDLE, psel=0.
  - SETUP: penable<=1 -> ACCESS. Exactly one cycle.
  - ACCESS:
    - pready=1: capture prdata (0 when pwrite=1) and pslverr, psel<=0, penable<=0, done[g]<=1 -> DONE;
    - pready=0: increment counter; when counter reaches TIMEOUT, psel/penable<=0, rsp_err<=1, rsp_rdata<=0, done[g]<=1 -> DONE.
  - DONE: done, rsp_rdata, rsp_err high/valid this cycle only, cleared next edge; pointer<=g+1 mod NUM_REQ; counter<=0 -> IDLE.
- Latency, zero-wait slave: req sampled in IDLE at edge 0; SETUP in cycle 1, ACCESS in cycle 2, DONE in cycle 3. Minimum 4 cycles per transfer, back-to-back rate 1 transfer per 4 cycles.
- paddr/pwrite/pwdata hold latched values from SETUP through ACCESS. They keep their last value in IDLE; no checks rely on them while psel=0.
- rsp_rdata/rsp_err are 0 whenever done=0.
- Arbitration:
  - pointer advances only on completion, including timeout completions;
  - requester holding req continuously is served again only after every other pending requester;
  - simultaneous requests resolve by pointer order only;
  - req arriving during SETUP/ACCESS/DONE waits for IDLE.
- pready or pslverr outside ACCESS: ignored.
- Timeout counter width: clog2(TIMEOUT+1). Slave asserting pready in the same cycle the counter hits TIMEOUT: pready wins (normal completion).
- At most one done bit high at any time.

Test Plan:
- Single write then read, zero-wait: req[0] write addr 0x10 data 0xA5A5_0001, then read 0x10 -> psel at cycle 1, penable at cycle 2, done[0] at cycle 3 each; read returns rsp_rdata=0xA5A5_0001, rsp_err=0.
- Round-robin fairness: req[0] and req[1] held high for 4 transfers each -> grant order 0,1,0,1,...; no requester granted twice in a row while the other is pending.
- Wait states and slave error: slave holds pready low 3 cycles then pready=1 with pslverr=1 -> penable stays high 4 ACCESS cycles, done with rsp_err=1, pointer advances.
- Timeout: slave never asserts pready, TIMEOUT=16 -> psel drops after 16 ACCESS cycles, done pulse with rsp_err=1, rsp_rdata=0; next pending requester proceeds.
- Reset mid-ACCESS: assert preset during ACCESS -> psel/penable/done go 0 asynchronously with no done pulse; after release, requester 1 and 0 pending -> requester 0 granted first.
- Field stability: requester changes req_addr/req_wdata after grant -> paddr/pwdata keep latched values through ACCESS; pready/pslverr toggled while IDLE produce no done.
